// File: rtl/selector_pipe_pkg.sv
// Shared constants, word type and depth helper for the selector pipeline.
// Optional index echo is controlled by SELECTOR_PIPE_INDEX_ECHO_EN.
package selector_pkg;

  localparam int unsigned DEFAULT_INPUTS     = 8;
  localparam int unsigned DEFAULT_INPUT_SIZE = 8;

  typedef logic [DEFAULT_INPUT_SIZE-1:0] word_t;

  // Tree depth; never below one level so a 2-input selector still registers.
  function automatic int unsigned levels(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/selector_pipe_if.sv
// Request/result bus of the selector pipeline (requester = master, pipe = slave).
// out_index exists only when SELECTOR_PIPE_INDEX_ECHO_EN is defined.
interface selector_pipe_if
  import selector_pkg::*;
#(
  parameter int unsigned INPUTS     = DEFAULT_INPUTS,
  parameter int unsigned INPUT_SIZE = DEFAULT_INPUT_SIZE
);

  localparam int unsigned LEVELS = levels(INPUTS);

  logic                  in_valid;
  logic                  in_ready;
  logic [LEVELS-1:0]     index;
  logic [INPUT_SIZE-1:0] values [INPUTS];
  logic                  out_valid;
  logic                  out_ready;
  logic [INPUT_SIZE-1:0] outcome;
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
  logic [LEVELS-1:0]     out_index;

  modport master (
    output in_valid, index, values, out_ready,
    input  in_ready, out_valid, outcome, out_index
  );

  modport slave (
    input  in_valid, index, values, out_ready,
    output in_ready, out_valid, outcome, out_index
  );
`else
  modport master (
    output in_valid, index, values, out_ready,
    input  in_ready, out_valid, outcome
  );

  modport slave (
    input  in_valid, index, values, out_ready,
    output in_ready, out_valid, outcome
  );
`endif

endinterface

// File: rtl/selector_pipe_level.sv
// One registered level of the OR-reduction tree: N words in, N/2 OR-ed pairs out.
// Independent of SELECTOR_PIPE_INDEX_ECHO_EN.
module selector_level #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [N*W-1:0]   data_i,
  output logic             valid_o,
  output logic [N/2*W-1:0] data_o
);

  logic             valid_q;
  logic [N/2*W-1:0] data_q;
  logic [N/2*W-1:0] data_d;

  always_comb begin
    data_d = '0;
    for (int unsigned j = 0; j < N / 2; j++) begin
      data_d[j*W +: W] = data_i[2*j*W +: W] | data_i[(2*j+1)*W +: W];
    end
  end

  // Data only loads behind a valid beat; a bubble just clears the valid bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/selector_pipe.sv
// Pipelined one-hot word selector: mask by index, OR-reduce over LEVELS registered levels.
// SELECTOR_PIPE_INDEX_ECHO_EN adds out_index, travelling in lockstep with outcome.
module selector_pipe_core
  import selector_pkg::*;
#(
  parameter int unsigned INPUTS     = DEFAULT_INPUTS,
  parameter int unsigned INPUT_SIZE = DEFAULT_INPUT_SIZE
) (
  input  logic          clock,
  input  logic          reset,
  selector_pipe_if.slave bus
);

  localparam int unsigned LEVELS = levels(INPUTS);

  logic                         advance;
  logic [INPUTS*INPUT_SIZE-1:0] masked;

  // Whole pipe moves together; in_ready depends only on the output side.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (bus.index == LEVELS'(i)) masked[i*INPUT_SIZE +: INPUT_SIZE] = bus.values[i];
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned N = INPUTS >> l;

    logic [N*INPUT_SIZE-1:0]   din;
    logic                      vin;
    logic [N/2*INPUT_SIZE-1:0] dout;
    logic                      vout;
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
    logic [LEVELS-1:0]         idx_in;
    logic [LEVELS-1:0]         idx_q;
`endif

    if (l == 0) begin : g_head
      assign din = masked;
      assign vin = bus.in_valid;
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
      assign idx_in = bus.index;
`endif
    end else begin : g_tail
      assign din = g_lvl[l-1].dout;
      assign vin = g_lvl[l-1].vout;
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
      assign idx_in = g_lvl[l-1].idx_q;
`endif
    end

    selector_level #(
      .N(N),
      .W(INPUT_SIZE)
    ) u_level (
      .clk_i  (clock),
      .rst_ni (reset),
      .en_i   (advance),
      .valid_i(vin),
      .data_i (din),
      .valid_o(vout),
      .data_o (dout)
    );

`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
    // Same enable and valid gating as the data path, so the echo never drifts.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        idx_q <= '0;
      end else if (advance && vin) begin
        idx_q <= idx_in;
      end
    end
`endif
  end

  assign bus.outcome   = g_lvl[LEVELS-1].dout;
  assign bus.out_valid = g_lvl[LEVELS-1].vout;
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
  assign bus.out_index = g_lvl[LEVELS-1].idx_q;
`endif

endmodule

module selector_pipe
  import selector_pkg::*;
#(
  parameter  int unsigned INPUTS     = DEFAULT_INPUTS,
  parameter  int unsigned INPUT_SIZE = DEFAULT_INPUT_SIZE,
  localparam int unsigned LEVELS     = levels(INPUTS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEVELS-1:0]     index,
  input  logic [INPUT_SIZE-1:0] values [INPUTS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUT_SIZE-1:0] outcome
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
  ,
  output logic [LEVELS-1:0]     out_index
`endif
);

  selector_pipe_if #(
    .INPUTS    (INPUTS),
    .INPUT_SIZE(INPUT_SIZE)
  ) u_bus ();

  assign u_bus.in_valid  = in_valid;
  assign u_bus.index     = index;
  assign u_bus.values    = values;
  assign u_bus.out_ready = out_ready;
  assign in_ready        = u_bus.in_ready;
  assign out_valid       = u_bus.out_valid;
  assign outcome         = u_bus.outcome;
`ifdef SELECTOR_PIPE_INDEX_ECHO_EN
  assign out_index       = u_bus.out_index;
`endif

  selector_pipe_core #(
    .INPUTS    (INPUTS),
    .INPUT_SIZE(INPUT_SIZE)
  ) u_core (
    .clock(clock),
    .reset(reset),
    .bus  (u_bus)
  );

endmodule
